// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding, flag struct and opcode helpers for the execute stage.
package alu_pkg;

  typedef enum logic [2:0] {
    PASS_B = 3'b000,
    ADD    = 3'b010,
    SUB    = 3'b011,
    AND    = 3'b100,
    OR     = 3'b101,
    XOR    = 3'b110
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  function automatic logic is_legal_op(input logic [2:0] cntrl);
    case (cntrl)
      PASS_B, ADD, SUB, AND, OR, XOR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic op_sets_cv(input logic [2:0] cntrl);
    return (cntrl == ADD) || (cntrl == SUB);
  endfunction

endpackage

// File: rtl/alu_ex_stage_if.sv
// Decode -> execute -> memory handshake bundle plus the architectural NZCV view.
interface alu_ex_stage_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_cntrl;
  logic             in_set_flags;
  logic [TAG_W-1:0] in_rd;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_rd;
  logic             out_negative;
  logic             out_zero;
  logic             out_overflow;
  logic             out_carry;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, in_a, in_b, in_cntrl, in_set_flags, in_rd, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd,
           out_negative, out_zero, out_overflow, out_carry,
           flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cntrl, in_set_flags, in_rd, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd,
           out_negative, out_zero, out_overflow, out_carry,
           flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/alu.sv
// Combinational WIDTH-bit ALU; illegal opcodes yield a zero result with all flags clear.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cntrl,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);
  logic [WIDTH:0] sum;
  logic           legal;

  assign legal = is_legal_op(cntrl);

  always_comb begin
    sum       = '0;
    result    = '0;
    carry_out = 1'b0;
    overflow  = 1'b0;
    case (cntrl)
      PASS_B: result = b;
      ADD: begin
        sum       = {1'b0, a} + {1'b0, b};
        result    = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
        overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      SUB: begin
        // carry is "no borrow": a + ~b + 1
        sum       = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        result    = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
        overflow  = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      AND:     result = a & b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      default: result = '0;
    endcase
  end

  assign negative = legal && result[WIDTH-1];
  assign zero     = legal && (result == '0);
endmodule

// File: rtl/nzcv_reg.sv
// Architectural NZCV register: N/Z follow any flag-setting op, C/V only arithmetic ones.
module nzcv_reg
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  upd,
  input  logic  set_cv,
  input  nzcv_t nxt,
  output nzcv_t flags
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= '0;
    end else if (upd) begin
      flags.n <= nxt.n;
      flags.z <= nxt.z;
      if (set_cv) begin
        flags.c <= nxt.c;
        flags.v <= nxt.v;
      end
    end
  end
endmodule

// File: rtl/alu_ex_stage.sv
// Two-stage execute wrapper around alu with valid/ready backpressure, flush and NZCV.
// Define ALU_EX_PERF_CNT_EN to add the perf_ops / perf_stalls counters.
module alu_ex_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  alu_ex_stage_if.slave bus
`ifdef ALU_EX_PERF_CNT_EN
  ,
  output logic [31:0]  perf_ops,
  output logic [31:0]  perf_stalls
`endif
);
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       cntrl;
    logic             set_flags;
    logic [TAG_W-1:0] rd;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] rd;
    nzcv_t            fl;
  } s2_t;

  s1_t              s1;
  s2_t              s2;
  logic             s1_valid, s2_valid;
  logic             s2_free, accept, advance, flag_upd;
  logic [WIDTH-1:0] alu_result;
  nzcv_t            alu_fl, arch_fl;

  assign s2_free    = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_free;
  assign accept     = bus.in_valid && bus.in_ready;
  assign advance    = s1_valid && s2_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1       <= '0;
      s2       <= '0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (accept)
        s1 <= '{a: bus.in_a, b: bus.in_b, cntrl: bus.in_cntrl,
                set_flags: bus.in_set_flags, rd: bus.in_rd};
      if (s2_free) s2_valid <= s1_valid;
      if (advance) s2 <= '{result: alu_result, rd: s1.rd, fl: alu_fl};
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a         (s1.a),
    .b         (s1.b),
    .cntrl     (s1.cntrl),
    .result    (alu_result),
    .negative  (alu_fl.n),
    .zero      (alu_fl.z),
    .carry_out (alu_fl.c),
    .overflow  (alu_fl.v)
  );

  // flag commit rides the S1->S2 move, and a flush suppresses it
  assign flag_upd = advance && !bus.flush && s1.set_flags && is_legal_op(s1.cntrl);

  nzcv_reg u_nzcv (
    .clk    (clk),
    .reset  (reset),
    .upd    (flag_upd),
    .set_cv (op_sets_cv(s1.cntrl)),
    .nxt    (alu_fl),
    .flags  (arch_fl)
  );

  assign bus.out_valid    = s2_valid;
  assign bus.out_result   = s2.result;
  assign bus.out_rd       = s2.rd;
  assign bus.out_negative = s2.fl.n;
  assign bus.out_zero     = s2.fl.z;
  assign bus.out_carry    = s2.fl.c;
  assign bus.out_overflow = s2.fl.v;
  assign bus.flag_n       = arch_fl.n;
  assign bus.flag_z       = arch_fl.z;
  assign bus.flag_c       = arch_fl.c;
  assign bus.flag_v       = arch_fl.v;

`ifdef ALU_EX_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ops    <= '0;
      perf_stalls <= '0;
    end else begin
      if (advance && !bus.flush)       perf_ops    <= perf_ops + 32'd1;
      if (s2_valid && !bus.out_ready)  perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_ex_stage.sv
// Bench for alu_ex_stage: vector table plus flush/reset/backpressure sequences, scoreboard checked.
module tb_alu_ex_stage;
  import alu_pkg::*;
  localparam int W = 64;
  localparam int T = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_ex_stage_if #(.WIDTH(W), .TAG_W(T)) bus ();
`ifdef ALU_EX_PERF_CNT_EN
  logic [31:0] perf_ops, perf_stalls;
`endif

  alu_ex_stage #(.WIDTH(W), .TAG_W(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_EX_PERF_CNT_EN
    ,
    .perf_ops    (perf_ops),
    .perf_stalls (perf_stalls)
`endif
  );

  typedef struct {
    logic [W-1:0] res;
    logic [T-1:0] rd;
    logic [3:0]   fl;
    logic [3:0]   nz;
    logic         lat;
    int           acc;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sf;
    logic [W-1:0] res;
    logic [3:0]   fl;
    logic [3:0]   nz;
  } vec_t;

  exp_t q[$];
  exp_t cur;
  vec_t vecs[12];
  int   n_chk = 0, n_fail = 0, cyc = 0, n_pop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] nzcv_now();
    return {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
  endfunction

  // Scoreboard: queue depth mirrors pipeline occupancy at each falling edge.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      chk("in_ready", {63'd0, bus.in_ready}, {63'd0, !(q.size() == 2 && !bus.out_ready)});
      if (bus.flush) begin
        q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_output", {63'd0, bus.out_valid}, 64'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            n_pop++;
            chk("result", bus.out_result, e.res);
            chk("rd", {59'd0, bus.out_rd}, {59'd0, e.rd});
            chk("op_flags", {60'd0, bus.out_negative, bus.out_zero, bus.out_carry, bus.out_overflow},
                {60'd0, e.fl});
            chk("nzcv", {60'd0, nzcv_now()}, {60'd0, e.nz});
            if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          cur.acc = cyc;
          q.push_back(cur);
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sf, input logic [T-1:0] rd, input logic [W-1:0] res,
                      input logic [3:0] fl, input logic [3:0] nz, input logic lat);
    logic got;
    got = 1'b0;
    bus.in_valid = 1'b1; bus.in_cntrl = op; bus.in_a = a; bus.in_b = b;
    bus.in_set_flags = sf; bus.in_rd = rd;
    cur = '{res: res, rd: rd, fl: fl, nz: nz, lat: lat, acc: 0};
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin got = 1'b1; break; end
    end
    chk("accept", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int pops0;
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_cntrl = '0;
    bus.in_set_flags = 0; bus.in_rd = '0; bus.flush = 0; bus.out_ready = 1;

    vecs[0]  = '{ADD,    64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 4'b1001, 4'b1001};
    vecs[1]  = '{SUB,    64'd5, 64'd5, 1'b1, 64'd0, 4'b0110, 4'b0110};
    vecs[2]  = '{AND,    64'd0, 64'd0, 1'b1, 64'd0, 4'b0100, 4'b0110};
    vecs[3]  = '{3'b111, 64'd3, 64'd4, 1'b1, 64'd0, 4'b0000, 4'b0110};
    vecs[4]  = '{3'b001, '1,    '1,    1'b1, 64'd0, 4'b0000, 4'b0110};
    vecs[5]  = '{OR,     64'hF0, 64'h0F, 1'b0, 64'hFF, 4'b0000, 4'b0110};
    vecs[6]  = '{XOR,    '1,    64'd0, 1'b1, '1,    4'b1000, 4'b1010};
    vecs[7]  = '{PASS_B, 64'd123, 64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 4'b1000, 4'b1010};
    vecs[8]  = '{ADD,    '1,    64'd1, 1'b1, 64'd0, 4'b0110, 4'b0110};
    vecs[9]  = '{SUB,    64'd0, 64'd1, 1'b1, '1,    4'b1000, 4'b1000};
    vecs[10] = '{SUB,    64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 4'b0011};
    vecs[11] = '{PASS_B, 64'd5, 64'd0, 1'b1, 64'd0, 4'b0100, 4'b0111};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_nzcv", {60'd0, nzcv_now()}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_out_result", bus.out_result, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // vector table, back-to-back
    for (int i = 0; i < 12; i++)
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sf, 5'(i), vecs[i].res, vecs[i].fl, vecs[i].nz, 1'b1);
    drain();

    // flush with both stages full and a flag-setting op waiting to advance
    bus.out_ready = 1'b0;
    send(ADD, 64'd1, 64'd1, 1'b0, 5'd20, 64'd2, 4'b0000, 4'b0111, 1'b0);
    send(SUB, 64'd0, 64'd1, 1'b1, 5'd21, '1, 4'b1000, 4'b1000, 1'b0);
    bus.out_ready = 1'b1; bus.flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_cntrl = SUB; bus.in_a = 64'd0; bus.in_b = 64'd1;
    bus.in_set_flags = 1'b1; bus.in_rd = 5'd22;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_nzcv", {60'd0, nzcv_now()}, 64'b0111);
    @(negedge clk);
    chk("flush_s1_empty", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk); #1;
    send(AND, 64'hFF, 64'h0F, 1'b1, 5'd23, 64'h0F, 4'b0000, 4'b0011, 1'b1);
    drain();

    // asynchronous reset mid-stream, after a flag-setting op reached S2
    send(ADD, '1, 64'd1, 1'b1, 5'd24, 64'd0, 4'b0110, 4'b0110, 1'b0);
    send(ADD, 64'd2, 64'd3, 1'b1, 5'd25, 64'd5, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst_nzcv", {60'd0, nzcv_now()}, 64'd0);
    chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("midrst_out_result", bus.out_result, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("postrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk); #1;

    // 8-op stream with a 3-cycle downstream stall
    pops0 = n_pop;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(ADD, 64'(i), 64'(i), 1'b0, 5'(i), 64'(2 * i),
               (i == 0) ? 4'b0100 : 4'b0000, 4'b0000, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", 64'(n_pop - pops0), 64'd8);
`ifdef ALU_EX_PERF_CNT_EN
    chk("perf_ops", {32'd0, perf_ops}, 64'd8);
    chk("perf_stalls", {32'd0, perf_stalls}, 64'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
Execute-stage wrapper for the 64-bit ALU (cntrl 000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR).
- Registers operands from decode and drives the existing alu instance.
- Captures result and flags into an output register that feeds the memory/writeback stage.
- Maintains the architectural NZCV flag register consumed by branch logic.
- Uses a two-stage valid/ready pipeline with backpressure and flush.

Parameters:
WIDTH, 64, datapath width (must match alu)
TAG_W, 5, destination-register tag width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  decode presents an op
in_ready  out  1  stage accepts op this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cntrl  in  3  ALU operation code
in_set_flags  in  1  op updates NZCV
in_rd  in  TAG_W  destination tag, passed through
flush  in  1  kill all in-flight ops
out_valid  out  1  result register holds a valid op
out_ready  in  1  downstream accepts result
out_result  out  WIDTH  registered ALU result
out_rd  out  TAG_W  registered tag
out_negative, out_zero, out_overflow, out_carry  out  1 each  registered per-op flags
flag_n, flag_z, flag_c, flag_v  out  1 each  architectural NZCV register

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, reset.
- Reset values:
  - s1_valid=0, s2_valid=0; all data and flag outputs 0.
  - NZCV=0000; in_ready=1 while reset is low.
- Stage 1 (S1):
  - Captures in_* when in_valid && in_ready.
  - The alu is driven combinationally from S1 registers.
- Stage 2 (S2):
  - Captures alu result, flags, rd and set_flags when s1_valid && s2_free, where s2_free = !s2_valid || out_ready.
- Ready rules:
  - in_ready = !s1_valid || s2_free (combinational; no dependence on in_valid).
  - out_valid = s2_valid.
  - S2 holds all outputs stable while out_valid && !out_ready.
- Latency and throughput:
  - Accepted op appears on out_* exactly 2 cycles later with no backpressure.
  - Full throughput is 1 op/cycle.
- NZCV update:
  - Occurs on the same edge an op moves S1->S2, only if its set_flags=1 and cntrl is legal.
  - ADD/SUB: all four flags from the alu.
  - Logical and PASS_B: N,Z from alu; C,V retain their old values.
- Illegal cntrl (001, 111):
  - Op flows through; out_result=0, per-op flags 0.
  - NZCV is never modified.
- Flush:
  - On the edge where flush=1, s1_valid and s2_valid are cleared.
  - An op presented with in_valid in that cycle is dropped.
  - No NZCV update occurs on that edge.
  - Data registers need not clear.
- Simultaneous events:
  - Flush beats accept, advance and flag update.
  - S2 drain and S1->S2 advance in the same cycle are legal.
  - S1 refill in that cycle is also legal.
- Reset mid-operation: immediately clears valids, outputs and NZCV, regardless of the clock.
- Width rules:
  - carry_out/overflow are taken from the alu unchanged.
  - zero is true iff all WIDTH result bits are 0; negative = result[WIDTH-1].

Optional Feature:
ALU_EX_PERF_CNT_EN:
- When defined, adds outputs perf_ops[31:0] and perf_stalls[31:0].
  - perf_ops increments on every S1->S2 transfer that is not flushed.
  - perf_stalls increments each cycle s2_valid && !out_ready.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum: PASS_B=3'b000, ADD=3'b010, SUB=3'b011, AND=3'b100, OR=3'b101, XOR=3'b110.
  - Function is_legal_op.
  - Function op_sets_cv (ADD/SUB).
  - Struct nzcv_t.
- Sub-module: the existing alu instantiated unmodified.
- Also natural: one small nzcv_reg sub-module holding the flag register and its update rule.

Test Plan:
- Reset with reset=1 mid-stream -> out_valid=0, NZCV=0000, in_ready=1 while reset is low.
- ADD A=64'h7FFFFFFFFFFFFFFF, B=1, set_flags=1 -> 2 cycles later out_result=64'h8000000000000000, out_overflow=1; NZCV=1001 (N=1, Z=0, C=0, V=1).
- SUB A=5, B=5, set_flags=1, then AND A=0, B=0, set_flags=1 -> after SUB NZCV=0110 (Z=1, C=1); after AND Z=1, N=0, C and V keep 1 and 0.
- Stream of 8 back-to-back ADD ops (A=i, B=i) with out_ready held 0 for 3 cycles mid-stream -> no op lost or duplicated, in order; in_ready=0 exactly while both stages are full; results 2i.
- Flush while both stages are valid and in_valid=1 with an op of set_flags=1 -> next cycle out_valid=0; NZCV unchanged; next accepted op unaffected.
- Illegal cntrl 3'b111 with set_flags=1 -> out_result=0, NZCV unchanged.
- Under ALU_EX_PERF_CNT_EN, 8 ops with 3 stall cycles -> perf_ops=8, perf_stalls=3.
